// File: rtl/fft_rotator_sequencer_if.sv
// Stream bundle for fft_rotator_sequencer: sample input stream and rotated output stream.
// A beat transfers on a rising edge where valid & ready are both high; valid holds its payload until then.
interface fft_rotator_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int IDX_WIDTH  = 4
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_r;
   logic signed [DATA_WIDTH-1:0] in_i;
   logic                         in_last;

   logic                         out_valid;
   logic                         out_ready;
   logic signed [DATA_WIDTH-1:0] out_r;
   logic signed [DATA_WIDTH-1:0] out_i;
   logic                         out_last;
   logic [IDX_WIDTH-1:0]         out_idx;

   modport master (
      output in_valid, in_r, in_i, in_last, out_ready,
      input  in_ready, out_valid, out_r, out_i, out_last, out_idx
   );

   modport slave (
      input  in_valid, in_r, in_i, in_last, out_ready,
      output in_ready, out_valid, out_r, out_i, out_last, out_idx
   );
endinterface

// File: rtl/fft_rotator_sequencer.sv
// Sequences the shared twiddle rotator between the radix-4 stages of a 16-point FFT.
// Optional macro ROTATOR_TRIVIAL_BYPASS_EN: unity twiddles (e = 0) bypass the rotator.
module fft_rotator_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int IDX_WIDTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic                         inverse,
   fft_rotator_sequencer_if.slave       bus,
   output logic [IDX_WIDTH-1:0]         tw_addr,
   output logic signed [DATA_WIDTH-1:0] rot_ip_r,
   output logic signed [DATA_WIDTH-1:0] rot_ip_i,
   input  logic signed [DATA_WIDTH-1:0] rot_out_r,
   input  logic signed [DATA_WIDTH-1:0] rot_out_i,
   output logic                         frame_err,
   output logic [7:0]                   frame_cnt,
   output logic                         dbg_state,
   output logic [IDX_WIDTH-1:0]         dbg_cnt
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;

   state_t                       state;
   logic [IDX_WIDTH-1:0]         cnt;
   logic [IDX_WIDTH-1:0]         e;
   logic                         accept;
   logic signed [DATA_WIDTH-1:0] res_r;
   logic signed [DATA_WIDTH-1:0] res_i;

   // Radix-4 twiddle exponent: (column index) * (row index), range 0..9.
   assign e       = {2'b00, cnt[3:2]} * {2'b00, cnt[1:0]};
   assign tw_addr = inverse ? (IDX_WIDTH'(0) - e) : e;

   assign rot_ip_r = bus.in_r;
   assign rot_ip_i = bus.in_i;

   assign bus.in_ready = enable & (~bus.out_valid | bus.out_ready);
   assign accept       = bus.in_valid & bus.in_ready;

`ifdef ROTATOR_TRIVIAL_BYPASS_EN
   assign res_r = (e == '0) ? bus.in_r : rot_out_r;
   assign res_i = (e == '0) ? bus.in_i : rot_out_i;
`else
   assign res_r = rot_out_r;
   assign res_i = rot_out_i;
`endif

   assign dbg_state = state;
   assign dbg_cnt   = cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         frame_cnt     <= '0;
         frame_err     <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_r     <= '0;
         bus.out_i     <= '0;
         bus.out_last  <= 1'b0;
         bus.out_idx   <= '0;
      end else begin
         frame_err <= 1'b0;
         if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_r     <= res_r;
            bus.out_i     <= res_i;
            bus.out_idx   <= cnt;
            // Any frame end (proper, early or missing last) realigns to index 0.
            if (bus.in_last || cnt == LAST_IDX) begin
               bus.out_last <= 1'b1;
               cnt          <= '0;
               state        <= IDLE;
               if (bus.in_last && cnt == LAST_IDX)
                  frame_cnt <= frame_cnt + 8'd1;
               else
                  frame_err <= 1'b1;
            end else begin
               bus.out_last <= 1'b0;
               cnt          <= cnt + 1'b1;
               state        <= RUN;
            end
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fft_rotator_sequencer.sv
// Directed bench for fft_rotator_sequencer with a simple stand-in rotator model.
module tb_fft_rotator_sequencer;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          inverse = 1'b0;
   logic          rot_force = 1'b0;
   logic [3:0]    tw_addr;
   logic signed [DW-1:0] rot_ip_r, rot_ip_i, rot_out_r, rot_out_i;
   logic          frame_err;
   logic [7:0]    frame_cnt;
   logic          dbg_state;
   logic [3:0]    dbg_cnt;
   int            total = 0;
   int            bad = 0;

   logic [3:0] tw_seq [0:15] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3,
                                 4'd0, 4'd2, 4'd4, 4'd6, 4'd0, 4'd3, 4'd6, 4'd9};

   fft_rotator_sequencer_if #(.DATA_WIDTH(DW), .IDX_WIDTH(4)) bus_i ();

   fft_rotator_sequencer #(.DATA_WIDTH(DW), .IDX_WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .inverse   (inverse),
      .bus       (bus_i.slave),
      .tw_addr   (tw_addr),
      .rot_ip_r  (rot_ip_r),
      .rot_ip_i  (rot_ip_i),
      .rot_out_r (rot_out_r),
      .rot_out_i (rot_out_i),
      .frame_err (frame_err),
      .frame_cnt (frame_cnt),
      .dbg_state (dbg_state),
      .dbg_cnt   (dbg_cnt)
   );

   always #5 clk = ~clk;

   // Stand-in rotator: r + addr, i - addr, or a fixed pair when forced.
   assign rot_out_r = rot_force ? 16'sh1111 : rot_ip_r + $signed({12'b0, tw_addr});
   assign rot_out_i = rot_force ? 16'sh2222 : rot_ip_i - $signed({12'b0, tw_addr});

   task automatic send(input logic [15:0] r, input logic [15:0] i, input logic last);
      @(negedge clk);
      bus_i.in_r = r; bus_i.in_i = i; bus_i.in_last = last; bus_i.in_valid = 1'b1;
      @(posedge clk); #1;
      bus_i.in_valid = 1'b0; bus_i.in_last = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({bus_i.out_valid, bus_i.out_last, frame_err, dbg_state, bus_i.in_ready} !== 5'b0) begin
         bad++; $display("FAIL reset_flags: got %b want 00000",
                         {bus_i.out_valid, bus_i.out_last, frame_err, dbg_state, bus_i.in_ready});
      end
      total++;
      if ({bus_i.out_r, bus_i.out_i} !== 32'h0) begin
         bad++; $display("FAIL reset_data: got %h want 00000000", {bus_i.out_r, bus_i.out_i});
      end
      total++;
      if ({bus_i.out_idx, dbg_cnt, frame_cnt} !== 16'h0) begin
         bad++; $display("FAIL reset_counts: got %h want 0000", {bus_i.out_idx, dbg_cnt, frame_cnt});
      end
      rst_n = 1'b1;
      enable = 1'b1;
      #1;
      total++;
      if (bus_i.in_ready !== 1'b1) begin
         bad++; $display("FAIL ready_after_reset: got %b want 1", bus_i.in_ready);
      end
   endtask

   task automatic test_frame();
      logic [15:0] exp_r, exp_i;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         bus_i.in_r = 16'h1000 + 16'(n); bus_i.in_i = 16'h0;
         bus_i.in_last = (n == 15); bus_i.in_valid = 1'b1;
         #1;
         total++;
         if (tw_addr !== tw_seq[n]) begin
            bad++; $display("FAIL frame_tw_addr[%0d]: got %0d want %0d", n, tw_addr, tw_seq[n]);
         end
         if (n > 0) begin
            exp_r = 16'h1000 + 16'(n - 1) + {12'b0, tw_seq[n-1]};
            exp_i = 16'h0 - {12'b0, tw_seq[n-1]};
            total++;
            if ({bus_i.out_valid, bus_i.out_last, frame_err, bus_i.out_idx, bus_i.out_r, bus_i.out_i}
                !== {1'b1, 1'b0, 1'b0, 4'(n - 1), exp_r, exp_i}) begin
               bad++; $display("FAIL frame_out[%0d]: got v%b l%b e%b idx%0d %h/%h want v1 l0 e0 idx%0d %h/%h",
                               n - 1, bus_i.out_valid, bus_i.out_last, frame_err, bus_i.out_idx,
                               bus_i.out_r, bus_i.out_i, n - 1, exp_r, exp_i);
            end
         end
      end
      total++;
      if (frame_cnt !== 8'd0) begin
         bad++; $display("FAIL frame_cnt_before: got %0d want 0", frame_cnt);
      end
      @(posedge clk); #1;
      bus_i.in_valid = 1'b0; bus_i.in_last = 1'b0;
      @(negedge clk);
      total++;
      if ({bus_i.out_valid, bus_i.out_last, frame_err, bus_i.out_idx, bus_i.out_r, frame_cnt, dbg_cnt}
          !== {1'b1, 1'b1, 1'b0, 4'd15, 16'h1018, 8'd1, 4'd0}) begin
         bad++; $display("FAIL frame_end: got v%b l%b e%b idx%0d r%h fc%0d cnt%0d want v1 l1 e0 idx15 r1018 fc1 cnt0",
                         bus_i.out_valid, bus_i.out_last, frame_err, bus_i.out_idx, bus_i.out_r,
                         frame_cnt, dbg_cnt);
      end
   endtask

   task automatic test_inverse();
      inverse = 1'b1;
      for (int k = 0; k < 5; k++) send(16'h2000 + 16'(k), 16'h0, 1'b0);
      @(negedge clk);
      bus_i.in_r = 16'h2005; bus_i.in_i = 16'h0; bus_i.in_valid = 1'b1; rot_force = 1'b1;
      #1;
      total++;
      if ({tw_addr, dbg_cnt} !== {4'd15, 4'd5}) begin
         bad++; $display("FAIL inv_tw_addr_cnt5: got %0d/%0d want 15/5", tw_addr, dbg_cnt);
      end
      @(posedge clk); #1;
      bus_i.in_valid = 1'b0; rot_force = 1'b0;
      @(negedge clk);
      total++;
      if ({bus_i.out_r, bus_i.out_i, bus_i.out_idx} !== {16'h1111, 16'h2222, 4'd5}) begin
         bad++; $display("FAIL inv_out: got %h/%h idx%0d want 1111/2222 idx5",
                         bus_i.out_r, bus_i.out_i, bus_i.out_idx);
      end
      bus_i.in_r = 16'h2006; bus_i.in_valid = 1'b1;
      #1;
      total++;
      if (tw_addr !== 4'd14) begin
         bad++; $display("FAIL inv_tw_addr_cnt6: got %0d want 14", tw_addr);
      end
      @(posedge clk); #1;
      bus_i.in_valid = 1'b0;
      inverse = 1'b0;
      for (int k = 7; k < 15; k++) send(16'h2000 + 16'(k), 16'h0, 1'b0);
      send(16'h200F, 16'h0, 1'b1);
      @(negedge clk);
      total++;
      if ({frame_cnt, frame_err, bus_i.out_last} !== {8'd2, 1'b0, 1'b1}) begin
         bad++; $display("FAIL inv_frame_end: got fc%0d e%b l%b want fc2 e0 l1",
                         frame_cnt, frame_err, bus_i.out_last);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus_i.in_r = 16'h0A00; bus_i.in_i = 16'h0050; bus_i.in_valid = 1'b1;
      @(posedge clk); #1;
      bus_i.out_ready = 1'b0;
      bus_i.in_r = 16'h0B00; bus_i.in_i = 16'h0060;
      for (int h = 0; h < 3; h++) begin
         @(negedge clk);
         total++;
         if ({bus_i.in_ready, bus_i.out_valid, bus_i.out_r, bus_i.out_i, bus_i.out_idx, dbg_cnt}
             !== {1'b0, 1'b1, 16'h0A00, 16'h0050, 4'd0, 4'd1}) begin
            bad++; $display("FAIL hold[%0d]: got rdy%b v%b %h/%h idx%0d cnt%0d want rdy0 v1 0a00/0050 idx0 cnt1",
                            h, bus_i.in_ready, bus_i.out_valid, bus_i.out_r, bus_i.out_i,
                            bus_i.out_idx, dbg_cnt);
         end
      end
      bus_i.out_ready = 1'b1;
      #1;
      total++;
      if (bus_i.in_ready !== 1'b1) begin
         bad++; $display("FAIL drain_ready: got %b want 1", bus_i.in_ready);
      end
      @(posedge clk); #1;
      bus_i.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({bus_i.out_valid, bus_i.out_r, bus_i.out_i, bus_i.out_idx} !== {1'b1, 16'h0B00, 16'h0060, 4'd1}) begin
         bad++; $display("FAIL replace: got v%b %h/%h idx%0d want v1 0b00/0060 idx1",
                         bus_i.out_valid, bus_i.out_r, bus_i.out_i, bus_i.out_idx);
      end
      @(negedge clk);
      total++;
      if (bus_i.out_valid !== 1'b0) begin
         bad++; $display("FAIL drain_clear: got %b want 0", bus_i.out_valid);
      end
   endtask

   task automatic test_early_last();
      for (int k = 2; k < 7; k++) send(16'h3000 + 16'(k), 16'h0, 1'b0);
      send(16'h3007, 16'h0, 1'b1);
      @(negedge clk);
      total++;
      if ({bus_i.out_last, bus_i.out_idx, frame_err, frame_cnt, dbg_cnt, dbg_state}
          !== {1'b1, 4'd7, 1'b1, 8'd2, 4'd0, 1'b0}) begin
         bad++; $display("FAIL early_last: got l%b idx%0d e%b fc%0d cnt%0d st%b want l1 idx7 e1 fc2 cnt0 st0",
                         bus_i.out_last, bus_i.out_idx, frame_err, frame_cnt, dbg_cnt, dbg_state);
      end
      @(negedge clk);
      total++;
      if (frame_err !== 1'b0) begin
         bad++; $display("FAIL early_err_pulse: got %b want 0", frame_err);
      end
      send(16'h3100, 16'h0, 1'b0);
      @(negedge clk);
      total++;
      if ({bus_i.out_idx, bus_i.out_last, frame_cnt} !== {4'd0, 1'b0, 8'd2}) begin
         bad++; $display("FAIL early_restart: got idx%0d l%b fc%0d want idx0 l0 fc2",
                         bus_i.out_idx, bus_i.out_last, frame_cnt);
      end
   endtask

   task automatic test_missing_last();
      for (int k = 1; k < 15; k++) send(16'h4000 + 16'(k), 16'h0, 1'b0);
      send(16'h400F, 16'h0, 1'b0);
      @(negedge clk);
      total++;
      if ({bus_i.out_last, bus_i.out_idx, frame_err, frame_cnt, dbg_cnt}
          !== {1'b1, 4'd15, 1'b1, 8'd2, 4'd0}) begin
         bad++; $display("FAIL missing_last: got l%b idx%0d e%b fc%0d cnt%0d want l1 idx15 e1 fc2 cnt0",
                         bus_i.out_last, bus_i.out_idx, frame_err, frame_cnt, dbg_cnt);
      end
   endtask

   task automatic test_enable_reset();
      for (int k = 0; k < 9; k++) send(16'h5000 + 16'(k), 16'h0, 1'b0);
      @(negedge clk);
      enable = 1'b0;
      bus_i.in_r = 16'h5009; bus_i.in_i = 16'h0; bus_i.in_valid = 1'b1;
      for (int h = 0; h < 4; h++) begin
         @(negedge clk);
         total++;
         if ({bus_i.in_ready, bus_i.out_valid, dbg_cnt} !== {1'b0, 1'b0, 4'd9}) begin
            bad++; $display("FAIL disabled[%0d]: got rdy%b v%b cnt%0d want rdy0 v0 cnt9",
                            h, bus_i.in_ready, bus_i.out_valid, dbg_cnt);
         end
      end
      enable = 1'b1;
      @(posedge clk); #1;
      bus_i.in_valid = 1'b0;
      bus_i.out_ready = 1'b0;
      @(negedge clk);
      total++;
      if ({bus_i.out_valid, bus_i.out_idx, bus_i.out_r} !== {1'b1, 4'd9, 16'h500B}) begin
         bad++; $display("FAIL resume: got v%b idx%0d r%h want v1 idx9 r500b",
                         bus_i.out_valid, bus_i.out_idx, bus_i.out_r);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus_i.out_valid, dbg_cnt, frame_cnt, dbg_state} !== {1'b0, 4'd0, 8'd0, 1'b0}) begin
         bad++; $display("FAIL async_reset: got v%b cnt%0d fc%0d st%b want v0 cnt0 fc0 st0",
                         bus_i.out_valid, dbg_cnt, frame_cnt, dbg_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus_i.out_ready = 1'b1;
   endtask

   task automatic test_bypass();
      logic [15:0] exp_r, exp_i;
`ifdef ROTATOR_TRIVIAL_BYPASS_EN
      exp_r = 16'h7FFF; exp_i = 16'h8000;
`else
      exp_r = 16'h1111; exp_i = 16'h2222;
`endif
      rot_force = 1'b1;
      @(negedge clk);
      bus_i.in_r = 16'h7FFF; bus_i.in_i = 16'h8000; bus_i.in_valid = 1'b1;
      #1;
      total++;
      if (tw_addr !== 4'd0) begin
         bad++; $display("FAIL bypass_tw_addr: got %0d want 0", tw_addr);
      end
      @(posedge clk); #1;
      bus_i.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({bus_i.out_r, bus_i.out_i} !== {exp_r, exp_i}) begin
         bad++; $display("FAIL bypass_out: got %h/%h want %h/%h", bus_i.out_r, bus_i.out_i, exp_r, exp_i);
      end
      rot_force = 1'b0;
   endtask

   initial begin
      bus_i.in_valid = 1'b0; bus_i.in_last = 1'b0; bus_i.in_r = '0; bus_i.in_i = '0;
      bus_i.out_ready = 1'b1;
      test_reset();
      test_frame();
      test_inverse();
      test_back_to_back();
      test_early_last();
      test_missing_last();
      test_enable_reset();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
